// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: entry type for the committed-store buffer.
package store_buffer_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } stb_entry_t;
endpackage

// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed stores drained one at a time to the dcache,
// flagging load-queue entries whose word overlaps any buffered store.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int STB_DEPTH = 4,
   parameter int LDQ_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [31:0]                enq_addr,
   input  logic [3:0]                 enq_wmask,
   input  logic [31:0]                enq_wdata,
   input  logic [LDQ_DEPTH-1:0][31:0] ldq_addr,
   output logic [LDQ_DEPTH-1:0]       has_conflicting_store,
   output logic                       dmem_valid,
   input  logic                       dmem_ready,
   output logic [31:0]                dmem_addr,
   output logic [3:0]                 dmem_wmask,
   output logic [31:0]                dmem_wdata,
   input  logic                       dmem_resp,
   output logic                       empty
);
   localparam int STB_IDX = $clog2(STB_DEPTH);
   localparam logic [STB_IDX:0] ONE = 1;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   state_t           r_state;
   stb_entry_t       r_stb [STB_DEPTH];
   logic [STB_IDX:0] r_head, r_tail;
   logic             w_full, w_enq, w_pop, w_more;
   stb_entry_t       w_head;
   assign w_full    = (r_head[STB_IDX-1:0] == r_tail[STB_IDX-1:0]) && (r_head[STB_IDX] != r_tail[STB_IDX]);
   assign empty     = r_head == r_tail;
   assign enq_ready = !w_full;
   assign w_enq     = enq_valid && enq_ready;
   assign w_pop     = (r_state == S_WAIT) && dmem_resp;
   // something is left to drain after the pop if more than one entry was held or one arrives now
   assign w_more    = ((r_tail - r_head) != ONE) || w_enq;
   assign w_head    = r_stb[r_head[STB_IDX-1:0]];
   assign dmem_valid = r_state == S_REQ;
   assign dmem_addr  = {w_head.addr[31:2], 2'b00};
   assign dmem_wmask = w_head.wmask;
   assign dmem_wdata = w_head.wdata;
   always_comb begin
      has_conflicting_store = '0;
      for (int i = 0; i < LDQ_DEPTH; i++)
         for (int j = 0; j < STB_DEPTH; j++)
            if (r_stb[j].valid && (r_stb[j].addr[31:2] == ldq_addr[i][31:2]))
               has_conflicting_store[i] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_head  <= '0;
         r_tail  <= '0;
         for (int i = 0; i < STB_DEPTH; i++) r_stb[i] <= '0;
      end else begin
         if (w_enq) begin
            r_stb[r_tail[STB_IDX-1:0]] <= '{valid: 1'b1, addr: enq_addr, wmask: enq_wmask, wdata: enq_wdata};
            r_tail <= r_tail + ONE;
         end
         if (w_pop) begin
            r_stb[r_head[STB_IDX-1:0]].valid <= 1'b0;
            r_head <= r_head + ONE;
         end
         case (r_state)
            S_IDLE:  if (!empty || w_enq) r_state <= S_REQ;
            S_REQ:   if (dmem_ready) r_state <= S_WAIT;
            S_WAIT:  if (dmem_resp) r_state <= w_more ? S_REQ : S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
   a_resp_only_in_wait: assert property (@(posedge clk) disable iff (!rst) dmem_resp |-> (r_state == S_WAIT));
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus checked every cycle against a
// queue-based model of the store buffer.
module tb_store_buffer;
   localparam int D = 4;
   localparam int L = 8;
   logic              clk = 0, rst = 0;
   logic              enq_valid = 0, enq_ready;
   logic [31:0]       enq_addr = 0, enq_wdata = 0;
   logic [3:0]        enq_wmask = 0;
   logic [L-1:0][31:0] ldq_addr = '0;
   logic [L-1:0]      has_conflicting_store;
   logic              dmem_valid, dmem_ready = 0, dmem_resp = 0, empty;
   logic [31:0]       dmem_addr, dmem_wdata;
   logic [3:0]        dmem_wmask;
   int total = 0, bad = 0;
   typedef struct { logic [31:0] a; logic [3:0] m; logic [31:0] d; } st_t;
   st_t q[$];
   bit  m_out = 0;
   always #5 clk = ~clk;
   store_buffer #(.STB_DEPTH(D), .LDQ_DEPTH(L)) dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
      .enq_wmask(enq_wmask), .enq_wdata(enq_wdata),
      .ldq_addr(ldq_addr), .has_conflicting_store(has_conflicting_store),
      .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
      .empty(empty)
   );
   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask
   // Model: stores wait in order; the head is requested unless a write is outstanding.
   always @(posedge clk or negedge rst) begin : model
      bit acc, pop, iss;
      if (!rst) begin
         q.delete();
         m_out = 0;
      end else begin
         acc = enq_valid && (q.size() < D);
         pop = m_out && dmem_resp;
         iss = !m_out && (q.size() > 0) && dmem_ready;
         if (pop) begin q.delete(0); m_out = 0; end
         if (iss) m_out = 1;
         if (acc) q.push_back('{enq_addr, enq_wmask, enq_wdata});
      end
   end
   always @(negedge clk) begin : compare
      logic [L-1:0] ec;
      if (rst) begin
         ec = '0;
         for (int i = 0; i < L; i++)
            for (int j = 0; j < q.size(); j++)
               if (q[j].a[31:2] == ldq_addr[i][31:2]) ec[i] = 1'b1;
         chk("empty", empty, q.size() == 0);
         chk("enq_ready", enq_ready, q.size() < D);
         chk("dmem_valid", dmem_valid, (q.size() > 0) && !m_out);
         chk("conflict", has_conflicting_store, ec);
         if ((q.size() > 0) && !m_out) begin
            chk("dmem_addr", dmem_addr, {q[0].a[31:2], 2'b00});
            chk("dmem_wmask", dmem_wmask, q[0].m);
            chk("dmem_wdata", dmem_wdata, q[0].d);
         end
      end
   end
   task automatic step(bit ev, logic [31:0] ea, logic [3:0] em, logic [31:0] ed, bit rdy, bit rsp);
      enq_valid = ev; enq_addr = ea; enq_wmask = em; enq_wdata = ed;
      dmem_ready = rdy; dmem_resp = rsp && m_out;
      @(posedge clk); #1;
   endtask
   task automatic drain();
      int n = 0;
      while (!empty && n < 60) begin
         step(0, 0, 0, 0, dmem_valid, !dmem_valid);
         n++;
      end
      chk("drain_done", empty, 1);
   endtask
   initial begin
      for (int i = 0; i < L; i++) ldq_addr[i] = 32'h3000_0000 + i * 32'h100;
      #12 rst = 1;
      @(posedge clk); #1;
      chk("rst_empty", empty, 1);
      chk("rst_ready", enq_ready, 1);
      chk("rst_dvalid", dmem_valid, 0);
      chk("rst_conf", has_conflicting_store, 0);
      // single store round trip
      step(1, 32'h1000_0004, 4'hf, 32'hDEAD_BEEF, 0, 0);
      chk("t1_dvalid", dmem_valid, 1);
      chk("t1_addr", dmem_addr, 32'h1000_0004);
      chk("t1_data", dmem_wdata, 32'hDEAD_BEEF);
      step(0, 0, 0, 0, 1, 0);
      chk("t1_wait_dvalid", dmem_valid, 0);
      chk("t1_wait_empty", empty, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t1_empty", empty, 1);
      // fill, overflow attempt, FIFO-order drain
      for (int k = 0; k < 4; k++) step(1, 32'h4000_0000 + k * 4, 4'h3, 32'h1111_0000 + k, 0, 0);
      chk("t2_full", enq_ready, 0);
      step(1, 32'h4000_0100, 4'hf, 32'hBAD0_0005, 0, 0);
      chk("t2_model_size", q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk("t2_order", dmem_wdata, 32'h1111_0000 + k);
         step(0, 0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0, 1);
         if (k == 0) chk("t2_ready_after_resp", enq_ready, 1);
      end
      chk("t2_empty", empty, 1);
      // conflict tracking through REQ/WAIT
      ldq_addr[2] = 32'h2000_0003;
      step(1, 32'h2000_0000, 4'h1, 32'h0000_00AA, 0, 0);
      chk("t3_conf_req", has_conflicting_store, 8'b0000_0100);
      step(0, 0, 0, 0, 1, 0);
      chk("t3_conf_wait", has_conflicting_store, 8'b0000_0100);
      step(0, 0, 0, 0, 0, 1);
      chk("t3_conf_clear", has_conflicting_store, 8'b0000_0000);
      // full buffer: pop and enqueue in the same cycle, then wrap
      for (int k = 0; k < 4; k++) step(1, 32'h5000_0000 + k * 4, 4'hf, 32'h5555_0000 + k, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 32'h5000_0040, 4'hc, 32'hAAAA_0005, 0, 1);
      chk("t4_refused_size", q.size(), 3);
      chk("t4_ready", enq_ready, 1);
      step(1, 32'h5000_0040, 4'hc, 32'hAAAA_0005, 0, 0);
      chk("t4_full_again", enq_ready, 0);
      chk("t4_head", dmem_wdata, 32'h5555_0001);
      drain();
      // asynchronous reset while a write is outstanding
      ldq_addr[0] = 32'h6000_0008;
      for (int k = 0; k < 3; k++) step(1, 32'h6000_0000 + k * 4, 4'hf, 32'h6666_0000 + k, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("t5_pre_conf", has_conflicting_store[0], 1);
      #2 rst = 0;
      #1;
      chk("t5_dvalid", dmem_valid, 0);
      chk("t5_empty", empty, 1);
      chk("t5_conf", has_conflicting_store, 0);
      chk("t5_ready", enq_ready, 1);
      @(posedge clk); #1 rst = 1;
      step(0, 0, 0, 0, 0, 0);
      // random traffic over a small address pool to provoke conflicts
      for (int c = 0; c < 3000; c++) begin
         if (c % 8 == 0)
            for (int i = 0; i < L; i++)
               ldq_addr[i] = 32'h7000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         step($urandom_range(0, 9) < 6,
              32'h7000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
              4'($urandom), $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
